// File: rtl/sdp_ram_rd_sched.sv
`timescale 1ns/1ps
// sdp_ram_rd_sched
// Read scheduler for NUM_RAMS simple-dual-port RAM banks. Requests are
// credit-gated so every accepted read has a guaranteed slot in the response
// FIFO. Each accepted read issues a one-cycle ram_reb pulse. It is then
// tracked through an RD_LAT+1 stage pipeline, captured into the FIFO and
// returned in acceptance order.
// Requests to a non-existent bank produce an error response of zero data.
// These responses use the same latency and the same ordering as normal reads.
// Optional feature: define SDP_RAM_RD_SCHED_STATS_EN to add the 16-bit
// saturating stall_cnt output (cycles with req_valid=1 and req_ready=0).
module sdp_ram_rd_sched #(
  parameter int NUM_RAMS   = 2,
  parameter int AW         = 11,
  parameter int DW         = 16,
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clkb,
  input  logic                      rstb,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [$clog2(NUM_RAMS):0] req_bank,
  input  logic [AW-1:0]             req_addr,
  output logic [NUM_RAMS-1:0]       ram_reb,
  output logic [AW-1:0]             ram_addrb [NUM_RAMS],
  output logic [NUM_RAMS-1:0]       ram_rstb,
  input  logic [DW-1:0]             ram_doutb [NUM_RAMS],
`ifdef SDP_RAM_RD_SCHED_STATS_EN
  output logic [15:0]               stall_cnt,
`endif
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DW-1:0]             rsp_data,
  output logic [$clog2(NUM_RAMS):0] rsp_bank,
  output logic                      rsp_err
);

  localparam int BW = $clog2(NUM_RAMS) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + BW + DW;  // FIFO entry layout: {err, bank, data}

  // Credits and handshakes
  logic [CW-1:0]       credit_r;
  logic [CW-1:0]       credit_nxt_s;
  logic                req_ready_r;
  logic                accept_s;
  logic                pop_s;
  logic                bank_ok_s;
  logic [NUM_RAMS-1:0] bank_sel_s;

  // Bank read port
  logic [NUM_RAMS-1:0] ram_reb_r;
  logic [AW-1:0]       ram_addrb_r [NUM_RAMS];

  // Read-tracking pipeline; stage RD_LAT lines up with valid ram_doutb
  logic [RD_LAT:0]     pipe_vld_r;
  logic [RD_LAT:0]     pipe_err_r;
  logic [BW-1:0]       pipe_bank_r [RD_LAT+1];

  // Response FIFO
  logic [DW-1:0]       cap_data_s;
  logic [EW-1:0]       cap_entry_s;
  logic [EW-1:0]       head_s;
  logic [EW-1:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [PW-1:0]       rd_nxt_s;
  logic [CW-1:0]       fifo_cnt_r;
  logic [CW-1:0]       fifo_cnt_nxt_s;

  // Registered response outputs
  logic                rsp_valid_r;
  logic [DW-1:0]       rsp_data_r;
  logic [BW-1:0]       rsp_bank_r;
  logic                rsp_err_r;

  // Handshake decode, bank one-hot select and next credit value
  always_comb begin
    accept_s   = req_valid & req_ready_r;
    pop_s      = rsp_valid_r & rsp_ready;
    bank_ok_s  = (req_bank < BW'(NUM_RAMS));
    bank_sel_s = {NUM_RAMS{1'b0}};
    for (int i = 0; i < NUM_RAMS; i++) begin
      bank_sel_s[i] = (req_bank == BW'(i));
    end
    credit_nxt_s = credit_r + CW'(accept_s) - CW'(pop_s);
  end

  // Credit counter; req_ready looks only at the registered credit, never at a same-cycle pop
  always_ff @(posedge clkb or posedge rstb) begin
    if (rstb) begin
      credit_r    <= {CW{1'b0}};
      req_ready_r <= 1'b0;
    end else begin
      credit_r    <= credit_nxt_s;
      req_ready_r <= (credit_nxt_s < CW'(FIFO_DEPTH));
    end
  end

  // Issue one-cycle read enable and hold each bank address until the next read to it
  always_ff @(posedge clkb or posedge rstb) begin
    if (rstb) begin
      ram_reb_r <= {NUM_RAMS{1'b0}};
      for (int i = 0; i < NUM_RAMS; i++) begin
        ram_addrb_r[i] <= {AW{1'b0}};
      end
    end else begin
      ram_reb_r <= accept_s ? bank_sel_s : {NUM_RAMS{1'b0}};
      for (int i = 0; i < NUM_RAMS; i++) begin
        if (accept_s && bank_sel_s[i]) begin
          ram_addrb_r[i] <= req_addr;
        end
      end
    end
  end

  // Track every accepted request (including errors) until its data is due
  always_ff @(posedge clkb or posedge rstb) begin
    if (rstb) begin
      pipe_vld_r <= {(RD_LAT+1){1'b0}};
      pipe_err_r <= {(RD_LAT+1){1'b0}};
      for (int k = 0; k <= RD_LAT; k++) begin
        pipe_bank_r[k] <= {BW{1'b0}};
      end
    end else begin
      pipe_vld_r     <= {pipe_vld_r[RD_LAT-1:0], accept_s};
      pipe_err_r     <= {pipe_err_r[RD_LAT-1:0], ~bank_ok_s};
      pipe_bank_r[0] <= req_bank;
      for (int k = 1; k <= RD_LAT; k++) begin
        pipe_bank_r[k] <= pipe_bank_r[k-1];
      end
    end
  end

  // Select the returning bank's data, and look ahead to the FIFO head after this edge
  always_comb begin
    cap_data_s = {DW{1'b0}};
    for (int i = 0; i < NUM_RAMS; i++) begin
      cap_data_s = cap_data_s |
                   ({DW{~pipe_err_r[RD_LAT] & (pipe_bank_r[RD_LAT] == BW'(i))}} & ram_doutb[i]);
    end
    cap_entry_s    = {pipe_err_r[RD_LAT], pipe_bank_r[RD_LAT], cap_data_s};
    fifo_cnt_nxt_s = fifo_cnt_r + CW'(pipe_vld_r[RD_LAT]) - CW'(pop_s);
    rd_nxt_s       = rd_ptr_r + PW'(pop_s);
    // A capture landing in the slot that becomes the head must bypass the array
    if (pipe_vld_r[RD_LAT] && (wr_ptr_r == rd_nxt_s)) begin
      head_s = cap_entry_s;
    end else begin
      head_s = fifo_mem_r[rd_nxt_s];
    end
  end

  // FIFO storage; credit gating guarantees a free slot whenever a capture arrives
  always_ff @(posedge clkb) begin
    if (pipe_vld_r[RD_LAT]) begin
      fifo_mem_r[wr_ptr_r] <= cap_entry_s;
    end
  end

  // FIFO pointers/occupancy and registered response outputs (held while stalled)
  always_ff @(posedge clkb or posedge rstb) begin
    if (rstb) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      fifo_cnt_r  <= {CW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DW{1'b0}};
      rsp_bank_r  <= {BW{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      if (pipe_vld_r[RD_LAT]) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r   <= rd_nxt_s;
      fifo_cnt_r <= fifo_cnt_nxt_s;
      if (fifo_cnt_nxt_s != {CW{1'b0}}) begin
        rsp_valid_r                           <= 1'b1;
        {rsp_err_r, rsp_bank_r, rsp_data_r}   <= head_s;
      end else begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

`ifdef SDP_RAM_RD_SCHED_STATS_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles where a request waits on credits
  always_ff @(posedge clkb or posedge rstb) begin
    if (rstb) begin
      stall_cnt_r <= 16'h0000;
    end else if (req_valid && !req_ready_r && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

  assign req_ready = req_ready_r;
  assign ram_reb   = ram_reb_r;
  assign ram_addrb = ram_addrb_r;
  assign ram_rstb  = {NUM_RAMS{rstb}};
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_bank  = rsp_bank_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_sdp_ram_rd_sched.sv
`timescale 1ns/1ps
// Bench for sdp_ram_rd_sched: bank RAM models, a queue-based reference model
// with timestamps, table-driven single requests and directed corner sequences.
module tb_sdp_ram_rd_sched;
  localparam int NUM_RAMS   = 2;
  localparam int AW         = 11;
  localparam int DW         = 16;
  localparam int RD_LAT     = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int BW         = $clog2(NUM_RAMS) + 1;

  typedef struct {
    logic          err;
    logic [BW-1:0] bank;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  typedef struct {
    logic [BW-1:0]       bank;
    logic [AW-1:0]       addr;
    logic [NUM_RAMS-1:0] exp_reb;
    logic                exp_err;
    logic [DW-1:0]       exp_data;
  } vec_t;

  logic                clkb = 1'b0;
  logic                rstb;
  logic                req_valid;
  logic                req_ready;
  logic [BW-1:0]       req_bank;
  logic [AW-1:0]       req_addr;
  logic [NUM_RAMS-1:0] ram_reb;
  logic [AW-1:0]       ram_addrb [NUM_RAMS];
  logic [NUM_RAMS-1:0] ram_rstb;
  logic [DW-1:0]       ram_doutb [NUM_RAMS];
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DW-1:0]       rsp_data;
  logic [BW-1:0]       rsp_bank;
  logic                rsp_err;
`ifdef SDP_RAM_RD_SCHED_STATS_EN
  logic [15:0]         stall_cnt;
`endif

  // Reference model state
  exp_t          q[$];
  int            cyc = 0;
  int            credit = 0;
  bit            m_ready = 1'b0;
  logic [AW-1:0] m_addr [NUM_RAMS];
  int            m_stall = 0;
  int            n_acc = 0;
  int            n_pop = 0;
  int            first_pop = -1;
  int            last_pop = -1;
  int            total = 0;
  int            bad = 0;
  vec_t          vecs [6];

  // RAM bank models: output pipeline of RD_LAT registers
  logic [DW-1:0] rd_pipe [NUM_RAMS][RD_LAT];

  always #5 clkb = ~clkb;

  sdp_ram_rd_sched #(
    .NUM_RAMS(NUM_RAMS), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clkb(clkb), .rstb(rstb),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_bank(req_bank), .req_addr(req_addr),
    .ram_reb(ram_reb), .ram_addrb(ram_addrb), .ram_rstb(ram_rstb), .ram_doutb(ram_doutb),
`ifdef SDP_RAM_RD_SCHED_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_bank(rsp_bank), .rsp_err(rsp_err)
  );

  function automatic logic [DW-1:0] memval(input int b, input logic [AW-1:0] a);
    logic [3:0] tag;
    tag = 4'(b + 1);
    return {tag, 1'b0, a};
  endfunction

  // RAM read pipeline: sample address on reb, then shift every cycle
  always @(posedge clkb) begin
    for (int b = 0; b < NUM_RAMS; b++) begin
      if (ram_rstb[b]) begin
        for (int s = 0; s < RD_LAT; s++) rd_pipe[b][s] <= '0;
      end else begin
        if (ram_reb[b]) rd_pipe[b][0] <= memval(b, ram_addrb[b]);
        for (int s = 1; s < RD_LAT; s++) rd_pipe[b][s] <= rd_pipe[b][s-1];
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_RAMS; b++) ram_doutb[b] = rd_pipe[b][RD_LAT-1];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].due <= cyc);
  endfunction

  // One clock: update the model with this cycle's handshakes, then compare all outputs
  task automatic tick();
    bit                  acc;
    bit                  pp;
    logic [NUM_RAMS-1:0] e_reb;
    exp_t                e;
    acc = req_valid && m_ready;
    pp  = m_valid() && rsp_ready;
    if (req_valid && !m_ready && m_stall < 65535) m_stall++;
    @(posedge clkb);
    cyc++;
    if (pp) begin
      void'(q.pop_front());
      n_pop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    e_reb = '0;
    if (acc) begin
      e.err  = (int'(req_bank) >= NUM_RAMS);
      e.bank = req_bank;
      e.data = e.err ? '0 : memval(int'(req_bank), req_addr);
      e.due  = cyc + RD_LAT + 1;
      q.push_back(e);
      for (int b = 0; b < NUM_RAMS; b++) begin
        if (int'(req_bank) == b) begin
          e_reb[b]  = 1'b1;
          m_addr[b] = req_addr;
        end
      end
      n_acc++;
    end
    credit  = credit + int'(acc) - int'(pp);
    m_ready = (credit < FIFO_DEPTH);
    #1;
    chk("req_ready", 32'(req_ready), 32'(m_ready));
    chk("ram_reb", 32'(ram_reb), 32'(e_reb));
    for (int b = 0; b < NUM_RAMS; b++) chk("ram_addrb", 32'(ram_addrb[b]), 32'(m_addr[b]));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid()));
    if (m_valid()) begin
      chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
      chk("rsp_bank", 32'(rsp_bank), 32'(q[0].bank));
      chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
    end
  endtask

  // Assert reset away from the edge, check cleared outputs, release, one idle cycle
  task automatic do_reset();
    req_valid = 1'b0;
    rstb = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_ram_reb", 32'(ram_reb), 32'd0);
    chk("rst_ram_rstb", 32'(ram_rstb), 32'h3);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_bank", 32'(rsp_bank), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    for (int b = 0; b < NUM_RAMS; b++) chk("rst_ram_addrb", 32'(ram_addrb[b]), 32'd0);
    q.delete();
    credit  = 0;
    m_ready = 1'b0;
    m_stall = 0;
    for (int b = 0; b < NUM_RAMS; b++) m_addr[b] = '0;
    repeat (2) @(posedge clkb);
    #1;
    rstb = 1'b0;
    #1;
    chk("rel_ram_rstb", 32'(ram_rstb), 32'd0);
    tick();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int stale;
    int got_d;
    int p0;
    int a0;
    rstb = 1'b1; req_valid = 1'b0; req_bank = '0; req_addr = '0; rsp_ready = 1'b1;
    for (int b = 0; b < NUM_RAMS; b++) m_addr[b] = '0;

    vecs[0] = '{2'd1, 11'h005, 2'b10, 1'b0, 16'h2005};
    vecs[1] = '{2'd0, 11'h7FF, 2'b01, 1'b0, 16'h17FF};
    vecs[2] = '{2'd2, 11'h123, 2'b00, 1'b1, 16'h0000};
    vecs[3] = '{2'd3, 11'h000, 2'b00, 1'b1, 16'h0000};
    vecs[4] = '{2'd0, 11'h000, 2'b01, 1'b0, 16'h1000};
    vecs[5] = '{2'd1, 11'h400, 2'b10, 1'b0, 16'h2400};

    do_reset();

    // Table: isolated requests, exact latency and payload
    for (int v = 0; v < 6; v++) begin
      int acc_cyc;
      int got_cyc;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_bank = vecs[v].bank; req_addr = vecs[v].addr;
      chk("tbl_ready", 32'(req_ready), 32'd1);
      tick();
      acc_cyc = cyc;
      req_valid = 1'b0;
      chk("tbl_reb", 32'(ram_reb), 32'(vecs[v].exp_reb));
      got_cyc = -1;
      for (int k = 0; k < 10 && got_cyc < 0; k++) begin
        tick();
        if (rsp_valid) begin
          got_cyc = cyc;
          chk("tbl_data", 32'(rsp_data), 32'(vecs[v].exp_data));
          chk("tbl_bank", 32'(rsp_bank), 32'(vecs[v].bank));
          chk("tbl_err", 32'(rsp_err), 32'(vecs[v].exp_err));
        end
      end
      chk("tbl_latency", 32'(got_cyc - acc_cyc), 32'd4);
      tick();
    end

    // 20 back-to-back requests, alternating banks
    begin
      int lows;
      lows = 0; p0 = n_pop; first_pop = -1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
        req_valid = 1'b1; req_bank = BW'(i % 2); req_addr = AW'($urandom);
        if (!req_ready) lows++;
        tick();
      end
      req_valid = 1'b0;
      repeat (8) tick();
      chk("b2b_ready_low", 32'(lows), 32'd0);
      chk("b2b_pops", 32'(n_pop - p0), 32'd20);
      chk("b2b_span", 32'(last_pop - first_pop), 32'd19);
    end

    // Fill credits with rsp_ready=0, then release
    rsp_ready = 1'b0; a0 = n_acc;
    for (int i = 0; i < 12; i++) begin
      req_valid = 1'b1; req_bank = BW'(i % 2); req_addr = AW'(11'h100 + i);
      tick();
    end
    req_valid = 1'b0;
    chk("fill_accepts", 32'(n_acc - a0), 32'd8);
    chk("fill_ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1; p0 = n_pop;
    tick();
    chk("fill_ready_back", 32'(req_ready), 32'd1);
    repeat (10) tick();
    chk("fill_pops", 32'(n_pop - p0), 32'd8);

    // Error request between two good neighbours
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_bank = 2'd0; req_addr = 11'h010; tick();
    req_bank = 2'd2; req_addr = 11'h020; tick();
    chk("err_no_reb", 32'(ram_reb), 32'd0);
    req_bank = 2'd1; req_addr = 11'h030; tick();
    req_valid = 1'b0;
    got_d = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rsp_valid && rsp_err) begin
        got_d++;
        chk("err_data", 32'(rsp_data), 32'd0);
        chk("err_bank", 32'(rsp_bank), 32'd2);
      end
    end
    chk("err_count", 32'(got_d), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_bank  = BW'($urandom_range(0, 3));
      req_addr  = AW'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (15) tick();

    // Reset with 3 reads in flight and 2 buffered responses
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_bank = BW'(i % 2); req_addr = AW'(11'h200 + i);
      tick();
    end
    req_valid = 1'b0;
    tick();
    do_reset();
    rsp_ready = 1'b1; stale = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rsp_valid) stale++;
    end
    chk("no_stale", 32'(stale), 32'd0);
    req_valid = 1'b1; req_bank = 2'd1; req_addr = 11'h0AB;
    tick();
    req_valid = 1'b0; got_d = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rsp_valid) begin
        got_d++;
        chk("post_rst_data", 32'(rsp_data), 32'h20AB);
      end
    end
    chk("post_rst_count", 32'(got_d), 32'd1);

`ifdef SDP_RAM_RD_SCHED_STATS_EN
    do_reset();
    chk("stall_reset", 32'(stall_cnt), 32'd0);
    rsp_ready = 1'b0; req_valid = 1'b1; req_bank = 2'd0; req_addr = 11'h001;
    repeat (18) tick();
    chk("stall_10", 32'(stall_cnt), 32'd10);
    repeat (70000) tick();
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    chk("stall_model", 32'(stall_cnt), 32'(m_stall));
    req_valid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
